// File: rtl/occ_interval_update_pkg.sv
// occ_interval_update_pkg: shared widths, base codes and FSM states for the Occ interval step.
package occ_interval_update_pkg;
   localparam int PTR_W = 8;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {BASE_A, BASE_C, BASE_G, BASE_T} base_e;
   typedef enum logic [1:0] {IDLE, READ, CALC, DONE} state_e;
endpackage

// File: rtl/occ_interval_update_if.sv
// occ_interval_update_if: request, Occ ROM and result signals of one backward-search step.
interface occ_interval_update_if;
   import occ_interval_update_pkg::*;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_base;
   logic [PTR_W-1:0]   in_k;
   logic [PTR_W-1:0]   in_l;
   logic [4*PTR_W-1:0] c_table;
   logic               rom_ce;
   logic [PTR_W-1:0]   rom_addr_1;
   logic [PTR_W-1:0]   rom_addr_2;
   logic [31:0]        rom_data_1;
   logic [31:0]        rom_data_2;
   logic               out_valid;
   logic               out_ready;
   logic [PTR_W-1:0]   out_k;
   logic [PTR_W-1:0]   out_l;
   logic               out_empty;
   logic               out_ovf;
   modport slave (
      input  in_valid, in_base, in_k, in_l, c_table, rom_data_1, rom_data_2, out_ready,
      output in_ready, rom_ce, rom_addr_1, rom_addr_2, out_valid, out_k, out_l, out_empty, out_ovf
   );
   modport master (
      output in_valid, in_base, in_k, in_l, c_table, rom_data_1, rom_data_2, out_ready,
      input  in_ready, rom_ce, rom_addr_1, rom_addr_2, out_valid, out_k, out_l, out_empty, out_ovf
   );
endinterface

// File: rtl/occ_interval_update_lane_sel.sv
// occ_lane_sel: picks the count of one base out of a packed {T,G,C,A} Occ word.
module occ_lane_sel
   import occ_interval_update_pkg::*;
(
   input  logic [31:0]      word_i,
   input  logic [1:0]       base_i,
   output logic [CNT_W-1:0] cnt_o
);
   assign cnt_o = word_i[base_i*CNT_W +: CNT_W];
endmodule

// File: rtl/occ_interval_update.sv
// occ_interval_update: one FM-index backward-search step, k'=C[a]+Occ(a,k-1)+1, l'=C[a]+Occ(a,l).
module occ_interval_update
   import occ_interval_update_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   occ_interval_update_if.slave bus
);
   state_e           state_q, state_d;
   logic [1:0]       base_q;
   logic [PTR_W-1:0] k_q, l_q, c_q, out_k_q, out_l_q;
   logic [CNT_W-1:0] occ_k_q, occ_l_q, lane_1, lane_2;
   logic [PTR_W:0]   sum_k, sum_l;
   logic             empty_q, ovf_q;

   occ_lane_sel u_sel_1 (.word_i(bus.rom_data_1), .base_i(base_q), .cnt_o(lane_1));
   occ_lane_sel u_sel_2 (.word_i(bus.rom_data_2), .base_i(base_q), .cnt_o(lane_2));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = state_q;
      state_d = (state_q == IDLE && bus.in_valid) ? READ :
                (state_q == READ)                 ? CALC :
                (state_q == CALC)                 ? DONE :
                (state_q == DONE && bus.out_ready) ? IDLE : state_q;
   end

   // Sums carry one extra bit so overflow and the empty compare see the true value
   assign sum_k = {1'b0, c_q} + {{(PTR_W-CNT_W+1){1'b0}}, occ_k_q} + 1'b1;
   assign sum_l = {1'b0, c_q} + {{(PTR_W-CNT_W+1){1'b0}}, occ_l_q};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         base_q  <= '0;
         k_q     <= '0;
         l_q     <= '0;
         c_q     <= '0;
         occ_k_q <= '0;
         occ_l_q <= '0;
         out_k_q <= '0;
         out_l_q <= '0;
         empty_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == IDLE && bus.in_valid) begin
         base_q <= bus.in_base;
         k_q    <= bus.in_k;
         l_q    <= bus.in_l;
         c_q    <= bus.c_table[bus.in_base*PTR_W +: PTR_W];
      end else if (state_q == READ) begin
         occ_k_q <= (k_q == '0) ? '0 : lane_1;
         occ_l_q <= lane_2;
      end else if (state_q == CALC) begin
         out_k_q <= sum_k[PTR_W-1:0];
         out_l_q <= sum_l[PTR_W-1:0];
         empty_q <= sum_k > sum_l;
         ovf_q   <= sum_k[PTR_W] | sum_l[PTR_W];
      end

   assign bus.in_ready   = state_q == IDLE;
   assign bus.rom_ce     = state_q == READ;
   assign bus.rom_addr_1 = (state_q == READ && k_q != '0) ? k_q - 1'b1 : '0;
   assign bus.rom_addr_2 = (state_q == READ) ? l_q : '0;
   assign bus.out_valid  = state_q == DONE;
   assign bus.out_k      = out_k_q;
   assign bus.out_l      = out_l_q;
   assign bus.out_empty  = empty_q;
   assign bus.out_ovf    = ovf_q;
endmodule

// File: tb/tb_occ_interval_update.sv
// tb_occ_interval_update: directed checks of the Occ interval step against hand-computed results.
module tb_occ_interval_update;
   import occ_interval_update_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   logic [31:0] mem [256];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   occ_interval_update_if bus ();
   occ_interval_update dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   assign bus.rom_data_1 = mem[bus.rom_addr_1];
   assign bus.rom_data_2 = mem[bus.rom_addr_2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] b, input logic [7:0] k, input logic [7:0] l);
      bus.in_valid = 1'b1;
      bus.in_base  = b;
      bus.in_k     = k;
      bus.in_l     = l;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rom_ce !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", bus.rom_ce); end
      checks++; if (bus.rom_addr_1 !== 8'd0 || bus.rom_addr_2 !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", bus.rom_addr_1, bus.rom_addr_2); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      checks++; if ({bus.out_k, bus.out_l, bus.out_empty, bus.out_ovf} !== 18'd0) begin failures++; $display("FAIL reset_outs got=%0d/%0d/%b/%b exp=0", bus.out_k, bus.out_l, bus.out_empty, bus.out_ovf); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_reset_mid_read();
      issue(BASE_C, 8'd5, 8'd9);
      checks++; if (bus.rom_ce !== 1'b1) begin failures++; $display("FAIL midrd_ce_before got=%b exp=1", bus.rom_ce); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rom_ce !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrd_abort got ce=%b v=%b exp 0/0", bus.rom_ce, bus.out_valid); end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrd_idle cyc=%0d got v=%b r=%b exp 0/1", i, bus.out_valid, bus.in_ready); end
      end
   endtask

   task automatic test_basic();
      issue(BASE_C, 8'd5, 8'd9);
      checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr_1 !== 8'd4 || bus.rom_addr_2 !== 8'd9) begin failures++; $display("FAIL basic_read got ce=%b a1=%0d a2=%0d exp 1/4/9", bus.rom_ce, bus.rom_addr_1, bus.rom_addr_2); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", bus.in_ready); end
      step();
      checks++; if (bus.rom_ce !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_calc got ce=%b v=%b exp 0/0", bus.rom_ce, bus.out_valid); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_k !== 8'd14 || bus.out_l !== 8'd16) begin failures++; $display("FAIL basic_kl got=%0d/%0d exp=14/16", bus.out_k, bus.out_l); end
      checks++; if (bus.out_empty !== 1'b0 || bus.out_ovf !== 1'b0 || bus.rom_ce !== 1'b0) begin failures++; $display("FAIL basic_flags got e=%b o=%b ce=%b exp 0/0/0", bus.out_empty, bus.out_ovf, bus.rom_ce); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_return got v=%b r=%b exp 0/1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_k_zero();
      issue(BASE_A, 8'd0, 8'd7);
      checks++; if (bus.rom_addr_1 !== 8'd0 || bus.rom_addr_2 !== 8'd7) begin failures++; $display("FAIL kzero_addr got=%0d/%0d exp=0/7", bus.rom_addr_1, bus.rom_addr_2); end
      step();
      step();
      checks++; if (bus.out_k !== 8'd1 || bus.out_l !== 8'd2 || bus.out_empty !== 1'b0) begin failures++; $display("FAIL kzero_kl got=%0d/%0d e=%b exp=1/2/0", bus.out_k, bus.out_l, bus.out_empty); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_empty();
      issue(BASE_G, 8'd3, 8'd3);
      step();
      step();
      checks++; if (bus.out_k !== 8'd22 || bus.out_l !== 8'd21 || bus.out_empty !== 1'b1) begin failures++; $display("FAIL empty_kl got=%0d/%0d e=%b exp=22/21/1", bus.out_k, bus.out_l, bus.out_empty); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      issue(BASE_C, 8'd5, 8'd9);
      step();
      step();
      bus.in_valid = 1'b1;
      bus.in_base  = BASE_A;
      bus.in_k     = 8'd0;
      bus.in_l     = 8'd7;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_k !== 8'd14 || bus.out_l !== 8'd16 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d got v=%b k=%0d l=%0d r=%b exp 1/14/16/0", i, bus.out_valid, bus.out_k, bus.out_l, bus.in_ready); end
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got r=%b v=%b exp 1/0", bus.in_ready, bus.out_valid); end
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.rom_ce !== 1'b1 || bus.rom_addr_2 !== 8'd7) begin failures++; $display("FAIL bp_accept got ce=%b a2=%0d exp 1/7", bus.rom_ce, bus.rom_addr_2); end
      step();
      step();
      checks++; if (bus.out_k !== 8'd1 || bus.out_l !== 8'd2) begin failures++; $display("FAIL bp_second got=%0d/%0d exp=1/2", bus.out_k, bus.out_l); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      bus.c_table = {8'd250, 8'd20, 8'd10, 8'd0};
      issue(BASE_T, 8'd40, 8'd50);
      step();
      step();
      checks++; if (bus.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.out_ovf); end
      checks++; if (bus.out_k !== 8'd0 || bus.out_l !== 8'd4 || bus.out_empty !== 1'b0) begin failures++; $display("FAIL ovf_kl got=%0d/%0d e=%b exp=0/4/0", bus.out_k, bus.out_l, bus.out_empty); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]  = 32'h0000_0005;
      mem[2]  = 32'h0001_0000;
      mem[3]  = 32'h0001_0000;
      mem[4]  = 32'h0000_0300;
      mem[7]  = 32'h0000_0002;
      mem[9]  = 32'h0000_0600;
      mem[39] = 32'h0500_0000;
      mem[50] = 32'h0A00_0000;
      bus.c_table   = {8'd30, 8'd20, 8'd10, 8'd0};
      bus.in_valid  = 1'b0;
      bus.in_base   = 2'd0;
      bus.in_k      = 8'd0;
      bus.in_l      = 8'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_reset_mid_read();
      test_basic();
      test_k_zero();
      test_empty();
      test_back_to_back();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
